// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the mips_cpu_avalon multicycle CPU.
//   - FSM state enumeration
//   - MIPS-I opcode / funct encodings for the supported subset
//   - instruction field extraction helpers
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    EXEC   = 3'd1,
    MEM    = 3'd2,
    WB     = 3'd3,
    HALTED = 3'd4
  } state_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] ir);
    return ir[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [25:0] f_idx(input logic [31:0] ir);
    return ir[25:0];
  endfunction

  function automatic logic [31:0] f_simm(input logic [31:0] ir);
    return {{16{ir[15]}}, ir[15:0]};
  endfunction

  function automatic logic [31:0] f_zimm(input logic [31:0] ir);
    return {16'h0000, ir[15:0]};
  endfunction

endpackage

// File: rtl/mips_cpu_avalon_if.sv
// mips_cpu_avalon_if: Avalon-MM bus between the CPU (master) and memory (slave).
//   address     master->slave  word-aligned byte address
//   read/write  master->slave  request strobes, never both high
//   writedata   master->slave  store data
//   byteenable  master->slave  byte lanes (always all four)
//   waitrequest slave->master  stall; request completes on an edge where it is 0
//   readdata    slave->master  load/fetch data, valid on the completing edge
interface mips_cpu_avalon_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit general purpose register file.
//   clk, rst_n      clock, asynchronous active-low clear of all registers
//   ra1_i/rd1_o     asynchronous read port 1
//   ra2_i/rd2_o     asynchronous read port 2
//   we_i/wa_i/wd_i  synchronous write port; writes to $0 are dropped
//   v0_o            live contents of $2
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] v0_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != 5'd0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
  assign v0_o  = regs_q[2];

endmodule

// File: rtl/mips_cpu_avalon.sv
// mips_cpu_avalon: multicycle MIPS-I subset CPU on a single Avalon-MM master.
//   clk          system clock
//   reset        asynchronous active-low reset
//   active       1 while executing, 0 once halted (jump to address 0)
//   register_v0  live contents of $2
//   bus          Avalon-MM master (instruction fetch and data access)
module mips_cpu_avalon
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     active,
  output logic [31:0]              register_v0,
  mips_cpu_avalon_if.master        bus
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        pend_q, pend_d;
  logic [31:0] target_q, target_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] simm, zimm, rs_val, rt_val;
  logic [31:0] pc_plus4, pc_plus8, npc, eaddr, btgt, jtgt;

  logic        ex_we;
  logic [4:0]  ex_wa;
  logic [31:0] ex_wd;
  logic        take;
  logic [31:0] tgt;
  logic        is_lw, is_sw;

  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  assign op    = f_op(ir_q);
  assign funct = f_funct(ir_q);
  assign rs    = f_rs(ir_q);
  assign rt    = f_rt(ir_q);
  assign rd    = f_rd(ir_q);
  assign shamt = f_shamt(ir_q);
  assign simm  = f_simm(ir_q);
  assign zimm  = f_zimm(ir_q);

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign eaddr    = rs_val + simm;
  assign btgt     = pc_plus4 + {simm[29:0], 2'b00};
  assign jtgt     = {pc_plus4[31:28], f_idx(ir_q), 2'b00};
  // A pending target belongs to the branch before this instruction, so this
  // instruction is the delay slot and control transfers after it.
  assign npc      = pend_q ? target_q : pc_plus4;

  mips_regfile u_regfile (
    .clk   (clk),
    .rst_n (reset),
    .ra1_i (rs),
    .ra2_i (rt),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd),
    .v0_o  (register_v0)
  );

  // Decode and ALU
  always_comb begin
    ex_we = 1'b0;
    ex_wa = '0;
    ex_wd = '0;
    take  = 1'b0;
    tgt   = '0;
    is_lw = 1'b0;
    is_sw = 1'b0;
    case (op)
      OP_RTYPE: begin
        ex_we = 1'b1;
        ex_wa = rd;
        case (funct)
          FN_SLL:  ex_wd = rt_val << shamt;
          FN_SRL:  ex_wd = rt_val >> shamt;
          FN_SRA:  ex_wd = $signed(rt_val) >>> shamt;
          FN_ADDU: ex_wd = rs_val + rt_val;
          FN_SUBU: ex_wd = rs_val - rt_val;
          FN_AND:  ex_wd = rs_val & rt_val;
          FN_OR:   ex_wd = rs_val | rt_val;
          FN_XOR:  ex_wd = rs_val ^ rt_val;
          FN_NOR:  ex_wd = ~(rs_val | rt_val);
          FN_SLT:  ex_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
          FN_SLTU: ex_wd = {31'd0, rs_val < rt_val};
          FN_JR: begin
            ex_we = 1'b0;
            take  = 1'b1;
            tgt   = rs_val;
          end
          FN_JALR: begin
            ex_wd = pc_plus8;
            take  = 1'b1;
            tgt   = rs_val;
          end
          default: ex_we = 1'b0;
        endcase
      end
      OP_J: begin
        take = 1'b1;
        tgt  = jtgt;
      end
      OP_JAL: begin
        take  = 1'b1;
        tgt   = jtgt;
        ex_we = 1'b1;
        ex_wa = 5'd31;
        ex_wd = pc_plus8;
      end
      OP_BEQ: begin
        take = (rs_val == rt_val);
        tgt  = btgt;
      end
      OP_BNE: begin
        take = (rs_val != rt_val);
        tgt  = btgt;
      end
      OP_ADDIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val + simm; end
      OP_SLTI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, $signed(rs_val) < $signed(simm)}; end
      OP_SLTIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, rs_val < simm}; end
      OP_ANDI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val & zimm; end
      OP_ORI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val | zimm; end
      OP_XORI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val ^ zimm; end
      OP_LUI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = {zimm[15:0], 16'h0000}; end
      OP_LW:    is_lw = 1'b1;
      OP_SW:    is_sw = 1'b1;
      default:  ;
    endcase
  end

  // Control FSM and bus sequencing
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    pend_d      = pend_q;
    target_d    = target_q;
    mdr_d       = mdr_q;
    address_d   = address_q;
    read_d      = read_q;
    write_d     = write_q;
    writedata_d = writedata_q;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    case (state_q)
      FETCH: begin
        // Bus outputs are registered, so a fetch takes one cycle to issue
        // and then waits for the completing edge.
        if (!read_q) begin
          read_d    = 1'b1;
          address_d = pc_q & WORD_MASK;
        end else if (!bus.waitrequest) begin
          read_d  = 1'b0;
          ir_d    = bus.readdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rf_we  = ex_we;
        rf_wa  = ex_wa;
        rf_wd  = ex_wd;
        pc_d   = npc;
        pend_d = take;
        if (take) begin
          target_d = tgt;
        end
        if (is_lw || is_sw) begin
          state_d   = MEM;
          address_d = eaddr & WORD_MASK;
          read_d    = is_lw;
          write_d   = is_sw;
          if (is_sw) begin
            writedata_d = rt_val;
          end
        end else begin
          state_d = (npc == '0) ? HALTED : FETCH;
        end
      end
      MEM: begin
        if (!bus.waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            mdr_d   = bus.readdata;
            state_d = WB;
          end else begin
            state_d = (pc_q == '0) ? HALTED : FETCH;
          end
        end
      end
      WB: begin
        rf_we   = 1'b1;
        rf_wa   = rt;
        rf_wd   = mdr_q;
        state_d = (pc_q == '0) ? HALTED : FETCH;
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      ir_q        <= '0;
      pend_q      <= 1'b0;
      target_q    <= '0;
      mdr_q       <= '0;
      address_q   <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      writedata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pend_q      <= pend_d;
      target_q    <= target_d;
      mdr_q       <= mdr_d;
      address_q   <= address_d;
      read_q      <= read_d;
      write_q     <= write_d;
      writedata_q <= writedata_d;
    end
  end

  assign active         = (state_q != HALTED);
  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = 4'b1111;

endmodule

// File: tb/tb_mips_cpu_avalon.sv
// tb_mips_cpu_avalon: self-checking bench for mips_cpu_avalon with an Avalon
// memory slave model (programmable wait states), a table of small programs,
// and a scoreboard of expected $v0 values popped when the CPU halts.
module tb_mips_cpu_avalon;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        active;
  logic [31:0] register_v0;

  mips_cpu_avalon_if bus ();

  mips_cpu_avalon #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .register_v0 (register_v0),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory slave model ----------------
  logic [31:0] rom [64];   // 0xBFC0_0000 region
  logic [31:0] ram [64];   // 0x0000_0000 region
  int unsigned ws = 0;
  int unsigned wcnt = 0;

  assign bus.waitrequest = (bus.read || bus.write) && (wcnt < ws);

  always @(posedge clk) begin
    if (bus.read || bus.write) begin
      if (bus.waitrequest) begin
        wcnt <= wcnt + 1;
      end else begin
        wcnt <= 0;
        if (bus.write) begin
          if (bus.address[31:28] == 4'hB) rom[bus.address[7:2]] = bus.writedata;
          else                            ram[bus.address[7:2]] = bus.writedata;
        end
      end
    end else begin
      wcnt <= 0;
    end
  end

  always @(negedge clk) begin
    bus.readdata = (bus.address[31:28] == 4'hB) ? rom[bus.address[7:2]] : ram[bus.address[7:2]];
  end

  // ---------------- bus monitor ----------------
  logic [65:0] prev_s, cur_s;
  logic        prev_hold = 1'b0;
  int unsigned stab_err = 0;
  int unsigned rw_both = 0;
  logic        got_first = 1'b0;
  logic [31:0] first_addr = '0;
  logic        first_rd = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_hold = 1'b0;
      got_first = 1'b0;
    end else begin
      cur_s = {bus.read, bus.write, bus.address, bus.writedata};
      if (prev_hold && (cur_s != prev_s)) stab_err++;
      if (bus.read && bus.write) rw_both++;
      if (!got_first && (bus.read || bus.write)) begin
        got_first  = 1'b1;
        first_addr = bus.address;
        first_rd   = bus.read;
      end
      prev_s    = cur_s;
      prev_hold = (bus.read || bus.write) && bus.waitrequest;
    end
  end

  // ---------------- programs and vector table ----------------
  logic [31:0] prog [64];

  typedef struct {
    int unsigned base;
    int unsigned len;
    int unsigned wait_states;
    logic [31:0] exp_v0;
  } vec_t;

  vec_t vecs [7];
  logic [31:0] exp_q [$];

  task automatic load_prog(input int unsigned base, input int unsigned len);
    for (int i = 0; i < 64; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
    for (int unsigned i = 0; i < len; i++) rom[i] = prog[base + i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check32("rst_read", {31'd0, bus.read}, 32'd0);
    check32("rst_write", {31'd0, bus.write}, 32'd0);
    check32("rst_addr", bus.address, 32'd0);
    check32("rst_wdata", bus.writedata, 32'd0);
    check32("rst_be", {28'd0, bus.byteenable}, 32'hF);
    check32("rst_v0", register_v0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check32("active_after_release", {31'd0, active}, 32'd1);
  endtask

  task automatic run_to_halt();
    for (int c = 0; c < 3000 && active; c++) @(negedge clk);
    check32("halted_in_budget", {31'd0, active}, 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got halt with empty expectation queue");
    end else begin
      check32("v0", register_v0, exp_q.pop_front());
    end
  endtask

  initial begin
    // P1 @0: ADDIU $2,$0,5; JR $0; NOP
    prog[0] = 32'h24020005; prog[1] = 32'h00000008; prog[2] = 32'h00000000;
    // P2 @3: LUI $3,0x1000; SW $3,0x10($0); LW $2,0x10($0); JR $0; NOP
    prog[3] = 32'h3C031000; prog[4] = 32'hAC030010; prog[5] = 32'h8C020010;
    prog[6] = 32'h00000008; prog[7] = 32'h00000000;
    // P3 @8: BEQ $0,$0,+2; ADDIU $2,$0,1; ADDIU $2,$2,100 (skipped); ADDIU $2,$2,2; JR $0; NOP
    prog[8]  = 32'h10000002; prog[9]  = 32'h24020001; prog[10] = 32'h24420064;
    prog[11] = 32'h24420002; prog[12] = 32'h00000008; prog[13] = 32'h00000000;
    // P4 @14: JAL +0x20; ADDIU $4,$0,1; SUBU $2,$0,$4; SLTU $5,$0,$2; XOR $2,$2,$5;
    //         ADDU $2,$2,$6; JR $0; NOP; [0x20] ADDIU $6,$0,7; JR $31; NOP
    prog[14] = 32'h0FF00008; prog[15] = 32'h24040001; prog[16] = 32'h00041023;
    prog[17] = 32'h0002282B; prog[18] = 32'h00451026; prog[19] = 32'h00461021;
    prog[20] = 32'h00000008; prog[21] = 32'h00000000; prog[22] = 32'h24060007;
    prog[23] = 32'h03E00008; prog[24] = 32'h00000000;
    // P5 @25: ORI $3,$0,0x8000; SLL $3,$3,16; SRA $4,$3,4; SLT $5,$4,$0; BNE $5,$0,+2;
    //         SRL $6,$4,28; ADDIU $2,$0,0x55 (skipped); XORI $2,$6,0xFFF0; JR $0; NOP
    prog[25] = 32'h34038000; prog[26] = 32'h00031C00; prog[27] = 32'h00032103;
    prog[28] = 32'h0080282A; prog[29] = 32'h14A00002; prog[30] = 32'h00043702;
    prog[31] = 32'h24020055; prog[32] = 32'h38C2FFF0; prog[33] = 32'h00000008;
    prog[34] = 32'h00000000;
    // P6 @35: ADDIU $2,$0,5; SW $2,0x10($0); JR $0; NOP
    prog[35] = 32'h24020005; prog[36] = 32'hAC020010; prog[37] = 32'h00000008;
    prog[38] = 32'h00000000;

    vecs[0] = '{base: 0,  len: 3,  wait_states: 0, exp_v0: 32'h0000_0005};
    vecs[1] = '{base: 3,  len: 5,  wait_states: 0, exp_v0: 32'h1000_0000};
    vecs[2] = '{base: 3,  len: 5,  wait_states: 3, exp_v0: 32'h1000_0000};
    vecs[3] = '{base: 8,  len: 6,  wait_states: 0, exp_v0: 32'h0000_0003};
    vecs[4] = '{base: 8,  len: 6,  wait_states: 2, exp_v0: 32'h0000_0003};
    vecs[5] = '{base: 14, len: 11, wait_states: 0, exp_v0: 32'h0000_0005};
    vecs[6] = '{base: 25, len: 10, wait_states: 1, exp_v0: 32'h0000_FFFF};

    for (int i = 0; i < 7; i++) begin
      ws = vecs[i].wait_states;
      load_prog(vecs[i].base, vecs[i].len);
      exp_q.push_back(vecs[i].exp_v0);
      do_reset();
      run_to_halt();
      check32("first_addr", first_addr, 32'hBFC0_0000);
      check32("first_is_read", {31'd0, first_rd}, 32'd1);
      check32("halt_bus_idle", {30'd0, bus.read, bus.write}, 32'd0);
      if (vecs[i].base == 3) check32("stored_word", ram[4], 32'h1000_0000);
      repeat (5) @(negedge clk);
      check32("v0_frozen", register_v0, vecs[i].exp_v0);
      check32("still_halted", {31'd0, active}, 32'd0);
    end

    // Reset pulled low while a store is stalled in MEM.
    ws = 3;
    load_prog(35, 4);
    do_reset();
    begin
      int c;
      for (c = 0; c < 200 && !bus.write; c++) @(negedge clk);
      check32("reached_mem_write", {31'd0, bus.write}, 32'd1);
    end
    check32("v0_before_abort", register_v0, 32'h0000_0005);
    #2 reset = 1'b0;
    #1;
    check32("abort_write", {31'd0, bus.write}, 32'd0);
    check32("abort_read", {31'd0, bus.read}, 32'd0);
    check32("abort_addr", bus.address, 32'd0);
    check32("abort_v0", register_v0, 32'd0);
    check32("abort_active", {31'd0, active}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.push_back(32'h0000_0005);
    run_to_halt();
    check32("post_abort_first_addr", first_addr, 32'hBFC0_0000);
    check32("post_abort_first_read", {31'd0, first_rd}, 32'd1);
    check32("post_abort_store", ram[4], 32'h0000_0005);

    check32("bus_stable_during_wait", stab_err, 32'd0);
    check32("read_write_exclusive", rw_both, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_avalon.md
Name: mips_cpu_avalon

Overview:
Multicycle 32-bit MIPS-I subset CPU with a single Avalon-MM master port for both instruction and data memory. It fetches from the reset vector and executes until a jump to address 0, then drops active. The $v0 register is exported for test observation. It sits directly on the memory bus model in the system bench.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, first fetch address after reset

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
active  out  1  1 while executing; 0 once halted
register_v0  out  32  current contents of GPR $2, combinational from register file
address  out  32  byte address, word-aligned (bits[1:0]=0)
write  out  1  Avalon write request
read  out  1  Avalon read request
waitrequest  in  1  slave stall; a request completes on the rising edge where it is 0
writedata  out  32  store data
byteenable  out  4  byte lanes; 4'b1111 for all accesses
readdata  in  32  read data, valid on the completing edge

Behaviour:
- Reset (reset=0, asynchronous): PC=RESET_VECTOR, state=FETCH, all GPRs=0, active=1, read=0, write=0, address=0, writedata=0, byteenable=4'b1111. Reset mid-operation aborts any pending bus request immediately.
- States: FETCH, EXEC, MEM, WB, HALTED.
- FETCH: read=1, address=PC. Hold read, address and byteenable stable while waitrequest=1. On the completing edge, latch readdata into IR, then go to EXEC.
- EXEC:
  - Decode and ALU; write the ALU/LUI/link result to the register file. This ends R-type, immediate and jump instructions.
  - LW/SW go to MEM.
  - Next PC: see delay-slot rule. If the resulting next PC is 0, go to HALTED; otherwise go to FETCH.
- MEM:
  - LW: read=1, address=rs+sext(imm).
  - SW: write=1, writedata=rt, same address.
  - Hold all bus signals while waitrequest=1. LW goes to WB (rt <= latched data); SW goes to FETCH.
- Never assert read and write together.
- Instructions:
  - R-type: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDIU, SLTIU, SLTI, ANDI, ORI, XORI (zero-extend for the logical ops), LUI, LW, SW, BEQ, BNE.
  - J-type: J, JAL (link $31 = PC+8).
  - Unsupported opcodes execute as NOP.
- Arithmetic is 32-bit wrap-around; no overflow exceptions.
- Writes to $0 are discarded; $0 always reads 0.
- Branch delay slot:
  - A taken branch/jump sets the target as pending; the next sequential instruction (PC+4) executes, then PC=target.
  - Branch target = PC_branch+4+(sext(imm)<<2).
  - J target = {PC+4[31:28], idx, 2'b00}.
- Halt: when PC would become 0x0000_0000, enter HALTED. The delay slot is executed first, so JR $0 halts after its delay slot. In HALTED: active=0, read=write=0, register file frozen, until reset.
- Unaligned addresses are not supported: address[1:0] is forced to 0.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct localparams;
  - state enum typedef (FETCH/EXEC/MEM/WB/HALTED);
  - instruction-field extraction functions.
- One sub-module, mips_regfile: 32x32, two async read ports, one sync write port, plus a dedicated $2 output. Async clear on reset.
- The top module contains the FSM, PC/delay-slot logic, the ALU and the bus interface.

Test Plan:
- ADDIU $2,$0,5; JR $0; NOP at 0xBFC00000 -> active=1 the cycle after reset release; active falls; register_v0=5 within 100 cycles.
- LUI $3,0x1000; SW $3,0x10($0); LW $2,0x10($0); JR $0; NOP -> register_v0=0x1000_0000.
- Slave holds waitrequest=1 for 3 cycles on every access -> read/address stay stable throughout; same final v0 as the zero-wait case.
- BEQ $0,$0,+2 with ADDIU $2,$0,1 in the delay slot and ADDIU $2,$2,2 at the target, then halt -> v0=3. The skipped instruction (ADDIU $2,$2,100) is not executed.
- JAL then JR $31 round trip; SLTU/SUBU with 0xFFFFFFFF operands -> v0 = expected wrap/compare value (e.g. 0-1 = 0xFFFFFFFF, SLTU(0,0xFFFFFFFF)=1).
- Pull reset low mid-MEM -> read/write drop immediately, GPRs=0; after release the first bus request is a read at 0xBFC00000.
